// File: rtl/timebase_prog_if.sv
// Control and status bundle of the programmable timebase: controller drives
// enable/clear/divisor/tap setup, the timebase returns its counter and strobes.
interface timebase_prog_if #(
    parameter int WIDTH = 26,
    parameter int NTAPS = 6,
    parameter int PRE_W = 8,
    parameter int SEL_W = $clog2(WIDTH)
);
    logic                   en;
    logic                   clr;
    logic [PRE_W-1:0]       div;
    logic [NTAPS*SEL_W-1:0] tap_sel;
    logic [NTAPS-1:0]       tap_mode;
    logic [WIDTH-1:0]       ticks;
    logic                   tick_stb;
    logic                   wrap_stb;
    logic [NTAPS-1:0]       taps;

    modport master (
        output en, clr, div, tap_sel, tap_mode,
        input  ticks, tick_stb, wrap_stb, taps
    );

    modport slave (
        input  en, clr, div, tap_sel, tap_mode,
        output ticks, tick_stb, wrap_stb, taps
    );
endinterface

// File: rtl/timebase_prog.sv
// Free-running prescaled tick counter with per-channel programmable edge strobes
// on any counter bit; shared timebase for blink, debounce and polling logic.
module timebase_prog #(
    parameter int WIDTH = 26,
    parameter int NTAPS = 6,
    parameter int PRE_W = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    timebase_prog_if.slave bus
);
    localparam int SEL_W  = $clog2(WIDTH);
    localparam int TPAD_W = 1 << SEL_W;
    localparam logic [SEL_W:0] WIDTH_L = (SEL_W + 1)'(WIDTH);

    logic [PRE_W-1:0]             pre_q, pre_d;
    logic [WIDTH-1:0]             ticks_q, ticks_d;
    logic                         tick_stb_q, tick_stb_d;
    logic                         wrap_stb_q, wrap_stb_d;
    logic [NTAPS-1:0]             prev_q, prev_d;
    logic [NTAPS-1:0]             taps_q, taps_d;
    logic [NTAPS-1:0][SEL_W-1:0]  sel_q, sel_d;
    logic [TPAD_W-1:0]            ticks_pad;
    logic                         inc;

    // pre above div (divisor lowered mid-count) counts as a match so it never runs away
    assign inc       = bus.en & ~bus.clr & (pre_q >= bus.div);
    assign ticks_pad = TPAD_W'(ticks_q);

    always_comb begin
        pre_d   = pre_q;
        ticks_d = ticks_q;
        if (bus.clr) begin
            pre_d   = '0;
            ticks_d = '0;
        end else if (bus.en) begin
            if (inc) begin
                pre_d   = '0;
                ticks_d = ticks_q + WIDTH'(1);
            end else begin
                pre_d   = pre_q + PRE_W'(1);
            end
        end
        tick_stb_d = inc;
        wrap_stb_d = inc & (&ticks_q);
    end

    for (genvar k = 0; k < NTAPS; k++) begin : g_tap
        logic [SEL_W-1:0] b;
        logic             in_range;
        logic             bit_v;

        assign b        = bus.tap_sel[k*SEL_W +: SEL_W];
        assign in_range = {1'b0, b} < WIDTH_L;
        assign bit_v    = ticks_pad[b] & in_range;
        assign sel_d[k] = b;
        assign prev_d[k] = bit_v & ~bus.clr;
        // a freshly changed select has stale history, so its first evaluation is masked
        assign taps_d[k] = ~bus.clr & in_range & (b == sel_q[k]) &
                           (bit_v ^ prev_q[k]) & (bus.tap_mode[k] | bit_v);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_q      <= '0;
            ticks_q    <= '0;
            tick_stb_q <= 1'b0;
            wrap_stb_q <= 1'b0;
            prev_q     <= '0;
            taps_q     <= '0;
            sel_q      <= '0;
        end else begin
            pre_q      <= pre_d;
            ticks_q    <= ticks_d;
            tick_stb_q <= tick_stb_d;
            wrap_stb_q <= wrap_stb_d;
            prev_q     <= prev_d;
            taps_q     <= taps_d;
            sel_q      <= sel_d;
        end
    end

    assign bus.ticks    = ticks_q;
    assign bus.tick_stb = tick_stb_q;
    assign bus.wrap_stb = wrap_stb_q;
    assign bus.taps     = taps_q;
endmodule

// File: tb/tb_timebase_prog.sv
// Bench for timebase_prog: cycle scoreboard on a 26-bit build plus scenario
// checks, and a 4-bit build for wrap behaviour.
module tb_timebase_prog;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    timebase_prog_if #(.WIDTH(26), .NTAPS(6), .PRE_W(8)) bus ();
    timebase_prog_if #(.WIDTH(4),  .NTAPS(1), .PRE_W(2)) bus_s ();

    timebase_prog #(.WIDTH(26), .NTAPS(6), .PRE_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );
    timebase_prog #(.WIDTH(4), .NTAPS(1), .PRE_W(2)) dut_s (
        .clk(clk), .rst_n(rst_n), .bus(bus_s)
    );

    typedef struct packed {
        logic [25:0] ticks;
        logic        stb;
        logic        wrap;
        logic [5:0]  taps;
    } exp_t;

    exp_t        sb_q[$];
    int          checks = 0;
    int          failures = 0;
    logic [7:0]  m_pre;
    logic [25:0] m_ticks;
    logic [5:0]  m_prev;
    int          m_sel[6];

    task automatic model_reset();
        m_pre = '0;
        m_ticks = '0;
        m_prev = '0;
        for (int k = 0; k < 6; k++) m_sel[k] = 0;
        sb_q.delete();
    endtask

    task automatic set_tap(input int k, input int s, input logic md);
        logic [4:0] s5;
        s5 = s[4:0];
        bus.tap_sel[k*5 +: 5] = s5;
        bus.tap_mode[k] = md;
    endtask

    // one clock: predict outputs from the driven inputs, then compare after the edge
    task automatic step();
        exp_t e, got;
        int   b;
        logic bv, inc;
        inc    = bus.en && !bus.clr && (m_pre >= bus.div);
        e.stb  = inc;
        e.wrap = inc && (m_ticks == 26'h3FF_FFFF);
        for (int k = 0; k < 6; k++) begin
            b  = int'(bus.tap_sel[k*5 +: 5]);
            bv = (b < 26) ? (((m_ticks >> b) & 26'd1) != 26'd0) : 1'b0;
            e.taps[k] = !bus.clr && (b < 26) && (b == m_sel[k]) &&
                        (bv != m_prev[k]) && (bus.tap_mode[k] || bv);
            m_prev[k] = bus.clr ? 1'b0 : bv;
            m_sel[k]  = b;
        end
        if (bus.clr) begin
            m_pre = '0;
            m_ticks = '0;
        end else if (bus.en) begin
            if (inc) begin
                m_pre = '0;
                m_ticks = m_ticks + 26'd1;
            end else begin
                m_pre = m_pre + 8'd1;
            end
        end
        e.ticks = m_ticks;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        got = {bus.ticks, bus.tick_stb, bus.wrap_stb, bus.taps};
        e = sb_q.pop_front();
        checks++;
        if (got !== e) begin
            failures++;
            $display("FAIL sb_cycle t=%0t ticks=%h stb=%b wrap=%b taps=%b required ticks=%h stb=%b wrap=%b taps=%b",
                     $time, got.ticks, got.stb, got.wrap, got.taps, e.ticks, e.stb, e.wrap, e.taps);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (bus.ticks !== 26'd0) begin failures++; $display("FAIL rst_ticks got=%h want=0", bus.ticks); end
        checks++; if (bus.tick_stb !== 1'b0) begin failures++; $display("FAIL rst_tick_stb got=%b want=0", bus.tick_stb); end
        checks++; if (bus.wrap_stb !== 1'b0) begin failures++; $display("FAIL rst_wrap_stb got=%b want=0", bus.wrap_stb); end
        checks++; if (bus.taps !== 6'd0) begin failures++; $display("FAIL rst_taps got=%b want=0", bus.taps); end
        checks++; if (bus_s.ticks !== 4'd0) begin failures++; $display("FAIL rst_small_ticks got=%h want=0", bus_s.ticks); end
        #3 rst_n = 1'b1;
        model_reset();
        step();
    endtask

    task automatic test_div0();
        bus.div = 8'd0;
        bus.en  = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            step();
            checks++; if (bus.ticks !== 26'(i)) begin failures++; $display("FAIL div0_ticks got=%0d want=%0d", bus.ticks, i); end
            checks++; if (bus.tick_stb !== 1'b1) begin failures++; $display("FAIL div0_stb got=%b want=1", bus.tick_stb); end
            checks++; if (bus.taps[0] !== (i >= 2)) begin failures++; $display("FAIL div0_tap0 i=%0d got=%b want=%b", i, bus.taps[0], i >= 2); end
        end
    endtask

    task automatic test_div2();
        logic [25:0] t0;
        int cnt;
        bus.div = 8'd2;
        t0 = bus.ticks;
        cnt = 0;
        repeat (9) begin
            step();
            if (bus.tick_stb === 1'b1) cnt++;
        end
        checks++; if (cnt != 3) begin failures++; $display("FAIL div2_stb_count got=%0d want=3", cnt); end
        checks++; if (bus.ticks !== t0 + 26'd3) begin failures++; $display("FAIL div2_ticks got=%0d want=%0d", bus.ticks, t0 + 26'd3); end
        step();
        step();
        bus.div = 8'd0;
        step();
        checks++; if (bus.tick_stb !== 1'b1) begin failures++; $display("FAIL div_drop_stb got=%b want=1", bus.tick_stb); end
        checks++; if (bus.ticks !== t0 + 26'd4) begin failures++; $display("FAIL div_drop_ticks got=%0d want=%0d", bus.ticks, t0 + 26'd4); end
        repeat (3) begin
            step();
            checks++; if (bus.tick_stb !== 1'b1) begin failures++; $display("FAIL div_drop_rate got=%b want=1", bus.tick_stb); end
        end
    endtask

    task automatic test_taps();
        int seen[$];
        int want0[3] = '{5, 13, 21};
        int want1[4] = '{5, 9, 13, 17};
        set_tap(0, 31, 1'b1);
        set_tap(1, 2, 1'b0);
        bus.clr = 1'b1; step(); bus.clr = 1'b0;
        repeat (24) begin
            step();
            if (bus.taps[1] === 1'b1) seen.push_back(int'(bus.ticks));
        end
        checks++; if (seen.size() != 3) begin failures++; $display("FAIL tap_rise_count got=%0d want=3", seen.size()); end
        for (int i = 0; i < 3 && i < seen.size(); i++) begin
            checks++; if (seen[i] != want0[i]) begin failures++; $display("FAIL tap_rise_at got=%0d want=%0d", seen[i], want0[i]); end
        end
        seen.delete();
        set_tap(1, 2, 1'b1);
        bus.clr = 1'b1; step(); bus.clr = 1'b0;
        repeat (20) begin
            step();
            if (bus.taps[1] === 1'b1) seen.push_back(int'(bus.ticks));
        end
        checks++; if (seen.size() != 4) begin failures++; $display("FAIL tap_any_count got=%0d want=4", seen.size()); end
        for (int i = 0; i < 4 && i < seen.size(); i++) begin
            checks++; if (seen[i] != want1[i]) begin failures++; $display("FAIL tap_any_at got=%0d want=%0d", seen[i], want1[i]); end
        end
        set_tap(1, 31, 1'b1);
    endtask

    task automatic test_wrap();
        int ex;
        bus.en = 1'b0;
        bus_s.div = 2'd0;
        bus_s.en  = 1'b1;
        for (int i = 1; i <= 40; i++) begin
            step();
            ex = i % 16;
            checks++; if (bus_s.ticks !== 4'(ex)) begin failures++; $display("FAIL wrap_ticks got=%0d want=%0d", bus_s.ticks, ex); end
            checks++; if (bus_s.wrap_stb !== (ex == 0)) begin failures++; $display("FAIL wrap_stb at=%0d got=%b want=%b", ex, bus_s.wrap_stb, ex == 0); end
            checks++; if (bus_s.taps[0] !== ((ex == 9) || (ex == 1 && i > 16))) begin
                failures++; $display("FAIL wrap_tap3 i=%0d got=%b want=%b", i, bus_s.taps[0], (ex == 9) || (ex == 1 && i > 16));
            end
        end
        bus_s.en = 1'b0;
    endtask

    task automatic test_clr_en();
        set_tap(0, 0, 1'b1);
        bus.en = 1'b1;
        bus.div = 8'd0;
        bus.clr = 1'b1; step(); bus.clr = 1'b0;
        for (int i = 0; i < 100 && m_ticks != 26'h2A; i++) step();
        checks++; if (bus.ticks !== 26'h2A) begin failures++; $display("FAIL clr_reach got=%h want=2a", bus.ticks); end
        bus.clr = 1'b1;
        step();
        checks++; if (bus.ticks !== 26'd0) begin failures++; $display("FAIL clr_ticks got=%h want=0", bus.ticks); end
        checks++; if ({bus.tick_stb, bus.wrap_stb} !== 2'b00) begin failures++; $display("FAIL clr_stb got=%b want=00", {bus.tick_stb, bus.wrap_stb}); end
        checks++; if (bus.taps !== 6'd0) begin failures++; $display("FAIL clr_taps got=%b want=0", bus.taps); end
        bus.clr = 1'b0;
        step();
        checks++; if (bus.taps !== 6'd0) begin failures++; $display("FAIL clr_release_taps got=%b want=0", bus.taps); end
        checks++; if (bus.ticks !== 26'd1) begin failures++; $display("FAIL clr_release_ticks got=%h want=1", bus.ticks); end
        bus.en = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            step();
            checks++; if (bus.ticks !== 26'd1) begin failures++; $display("FAIL freeze_ticks got=%h want=1", bus.ticks); end
            checks++; if (bus.tick_stb !== 1'b0) begin failures++; $display("FAIL freeze_stb got=%b want=0", bus.tick_stb); end
            if (i >= 2) begin
                checks++; if (bus.taps !== 6'd0) begin failures++; $display("FAIL freeze_taps got=%b want=0", bus.taps); end
            end
        end
    endtask

    task automatic test_sel_change();
        int seen[$];
        set_tap(0, 0, 1'b0);
        bus.en = 1'b1;
        bus.clr = 1'b1; step(); bus.clr = 1'b0;
        for (int i = 0; i < 100 && m_ticks != 26'h1F; i++) step();
        checks++; if (bus.ticks !== 26'h1F) begin failures++; $display("FAIL sel_reach got=%h want=1f", bus.ticks); end
        set_tap(0, 5, 1'b0);
        for (int i = 0; i < 100 && m_ticks != 26'h45; i++) begin
            step();
            if (bus.taps[0] === 1'b1) seen.push_back(int'(bus.ticks));
        end
        checks++; if (seen.size() != 1) begin failures++; $display("FAIL sel5_count got=%0d want=1", seen.size()); end
        if (seen.size() > 0) begin
            checks++; if (seen[0] != 'h21) begin failures++; $display("FAIL sel5_at got=%h want=21", seen[0]); end
        end
        set_tap(0, 0, 1'b0);
        step();
        checks++; if (bus.taps[0] !== 1'b0) begin failures++; $display("FAIL sel_back_mask got=%b want=0", bus.taps[0]); end
        step();
        checks++; if (bus.taps[0] !== 1'b0) begin failures++; $display("FAIL sel_back_fall got=%b want=0", bus.taps[0]); end
        step();
        checks++; if (bus.taps[0] !== 1'b1 || bus.ticks !== 26'h48) begin
            failures++; $display("FAIL sel_back_rise got tap=%b ticks=%h want tap=1 ticks=48", bus.taps[0], bus.ticks);
        end
    endtask

    task automatic test_reset_mid();
        set_tap(0, 0, 1'b1);
        repeat (5) step();
        #3 rst_n = 1'b0;
        #1;
        checks++; if (bus.ticks !== 26'd0) begin failures++; $display("FAIL rstmid_ticks got=%h want=0", bus.ticks); end
        checks++; if ({bus.tick_stb, bus.wrap_stb, bus.taps} !== 8'd0) begin
            failures++; $display("FAIL rstmid_strobes got=%b want=0", {bus.tick_stb, bus.wrap_stb, bus.taps});
        end
        @(posedge clk);
        #1;
        checks++; if (bus.ticks !== 26'd0) begin failures++; $display("FAIL rstmid_hold got=%h want=0", bus.ticks); end
        #3 rst_n = 1'b1;
        model_reset();
        step();
        checks++; if (bus.ticks !== 26'd1) begin failures++; $display("FAIL rstmid_resume got=%h want=1", bus.ticks); end
        repeat (4) step();
    endtask

    initial begin
        bus.en = 1'b0;
        bus.clr = 1'b0;
        bus.div = '0;
        bus.tap_sel = '0;
        bus.tap_mode = '0;
        bus_s.en = 1'b0;
        bus_s.clr = 1'b0;
        bus_s.div = '0;
        bus_s.tap_sel = 2'd3;
        bus_s.tap_mode = 1'b1;
        set_tap(0, 0, 1'b1);
        set_tap(1, 31, 1'b1);
        set_tap(2, 31, 1'b1);
        set_tap(3, 26, 1'b1);
        set_tap(4, 30, 1'b1);
        set_tap(5, 27, 1'b1);
        model_reset();
        test_reset();
        test_div0();
        test_div2();
        test_taps();
        test_wrap();
        test_clr_en();
        test_sel_change();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired at t=%0t", $time);
        $fatal(1, "bench time limit reached");
    end
endmodule
